// File: rtl/eigen_iteration_ctrl.sv
// -----------------------------------------------------------------------------
// eigen_iteration_ctrl
//
// Purpose:
//   Sequences an external eigenrecursion step unit. A run seeds a working
//   vector from vector_init, then repeatedly pulses the step unit's reset
//   (CLEAR), holds its start level (RUN) until it reports finished, captures
//   its result and decides (CHECK) whether to stop. A run stops after
//   MAX_ITER steps or, when the convergence comparator is built in, as soon
//   as two successive vectors agree in their top CMP_BITS bits per element.
//
// Build option:
//   EIGEN_CONV_CHECK_EN  defined   -> convergence comparator and previous-
//                                     vector register are built.
//                        undefined -> no comparator, converged is tied to 0,
//                                     every run performs exactly MAX_ITER steps.
//
// Handshake with the step unit (level based):
//   er_rst is a one-cycle clear before each step. er_start is held high for
//   the whole RUN state; the step unit raises er_f once er_vector_out is
//   valid. er_f is only sampled in RUN, so a stale er_f elsewhere is harmless.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active low
//   start          in   run request (only honoured in IDLE)
//   vector_init    in   SIZE_N x 64-bit seed vector
//   er_rst         out  step-unit reset (active high): rst low, or CLEAR
//   er_start       out  step-unit start level (high in RUN)
//   er_vector_in   out  step-unit input vector (= working vector)
//   er_vector_out  in   step-unit result vector
//   er_f           in   step-unit finished level
//   vector_result  out  working vector
//   iterations     out  completed steps in the current/last run
//   converged      out  run ended on convergence
//   busy           out  high in LOAD, CLEAR, RUN, CHECK
//   f              out  run done (high in DONE)
//   o_state        out  current FSM state (debug)
// -----------------------------------------------------------------------------
module eigen_iteration_ctrl #(
    parameter int SIZE_N   = 8,
    parameter int MAX_ITER = 16,
    parameter int CMP_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SIZE_N-1:0][63:0]  vector_init,
    output logic                     er_rst,
    output logic                     er_start,
    output logic [SIZE_N-1:0][63:0]  er_vector_in,
    input  logic [SIZE_N-1:0][63:0]  er_vector_out,
    input  logic                     er_f,
    output logic [SIZE_N-1:0][63:0]  vector_result,
    output logic [7:0]               iterations,
    output logic                     converged,
    output logic                     busy,
    output logic                     f,
    output logic [2:0]               o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] LP_MAX_ITER = 8'(MAX_ITER);

    state_t                    r_state;
    state_t                    w_next;
    logic [SIZE_N-1:0][63:0]   r_vec;
    logic [7:0]                r_iter;
    logic                      w_match;
    logic                      w_limit;

`ifdef EIGEN_CONV_CHECK_EN
    logic [SIZE_N-1:0][63:0]   r_prev;
    logic                      r_conv;

    // All elements must agree in their top CMP_BITS bits with the vector
    // from the previous step (or the seed, for the first step).
    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < SIZE_N; i++) begin
            if (r_vec[i][63 -: CMP_BITS] != r_prev[i][63 -: CMP_BITS]) begin
                w_match = 1'b0;
            end
        end
    end

    assign converged = r_conv;
`else
    assign w_match   = 1'b0;
    assign converged = 1'b0;
`endif

    assign w_limit = (r_iter == LP_MAX_ITER);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_CLEAR;
            S_CLEAR: w_next = S_RUN;
            S_RUN:   w_next = er_f ? S_CHECK : S_RUN;
            S_CHECK: w_next = (w_match || w_limit) ? S_DONE : S_CLEAR;
            S_DONE:  w_next = start ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = 1'b0;
        f        = 1'b0;
        er_start = 1'b0;
        // er_rst also follows the controller's own reset combinationally so
        // the step unit is held in reset for exactly as long as we are.
        er_rst   = !rst;
        case (r_state)
            S_LOAD:  busy = 1'b1;
            S_CLEAR: begin
                busy   = 1'b1;
                er_rst = 1'b1;
            end
            S_RUN: begin
                busy     = 1'b1;
                er_start = 1'b1;
            end
            S_CHECK: busy = 1'b1;
            S_DONE:  f = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vec  <= '0;
            r_iter <= '0;
`ifdef EIGEN_CONV_CHECK_EN
            r_prev <= '0;
            r_conv <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_vec  <= vector_init;
                    r_iter <= '0;
`ifdef EIGEN_CONV_CHECK_EN
                    r_prev <= vector_init;
                    r_conv <= 1'b0;
`endif
                end
                S_RUN: begin
                    if (er_f) begin
                        r_vec  <= er_vector_out;
                        r_iter <= r_iter + 8'd1;
`ifdef EIGEN_CONV_CHECK_EN
                        r_prev <= r_vec;
`endif
                    end
                end
`ifdef EIGEN_CONV_CHECK_EN
                S_CHECK: begin
                    if (w_match) begin
                        r_conv <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign er_vector_in  = r_vec;
    assign vector_result = r_vec;
    assign iterations    = r_iter;
    assign o_state       = r_state;

endmodule
